// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-source round-robin mux arbiter.
// State encoding, source ids and grant helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_G0,
        ARB_G1
    } arb_state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    function automatic logic [1:0] gnt_of(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two packet sources, the arbiter and one sink.
// slave = arbiter side, master = sources/sink side.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             valid0;
    logic             last0;
    logic [WIDTH-1:0] data0;
    logic             ready0;
    logic             req1;
    logic             valid1;
    logic             last1;
    logic [WIDTH-1:0] data1;
    logic             ready1;
    logic             out_valid;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;
    logic [1:0]       gnt;

    modport slave (
        input  req0, valid0, last0, data0,
        input  req1, valid1, last1, data1,
        input  out_ready,
        output ready0, ready1,
        output out_valid, out_last, out_data,
        output sel, gnt
    );

    modport master (
        output req0, valid0, last0, data0,
        output req1, valid1, last1, data1,
        output out_ready,
        input  ready0, ready1,
        input  out_valid, out_last, out_data,
        input  sel, gnt
    );
endinterface

// File: rtl/mux2_rr_arbiter_mux.sv
// Combinational 2:1 mux of {last,data} with grant-gated valid steering.
// Only the granted source can ever raise valid at the sink.
module arb_data_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [1:0]       gnt,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             last0,
    input  logic             last1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             valid,
    output logic             last,
    output logic [WIDTH-1:0] data
);

    assign valid = (gnt[0] & valid0) | (gnt[1] & valid1);
    assign {last, data} = sel ? {last1, data1} : {last0, data0};

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two packet sources.
// Grants per packet, caps grants at MAX_BEATS beats, hands over without bubbles.
module mux2_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input logic                clk,
    input logic                rst,
    mux2_rr_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t       state;
    logic             prio;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       gnt;
    logic             sel;
    logic [1:0]       req;
    logic             mux_valid;
    logic             xfer;
    logic             cur;
    logic             at_cap;
    logic             release_now;
    logic             nxt_go;
    logic             nxt_src;

    arb_data_mux2 #(.WIDTH(WIDTH)) u_mux (
        .sel    (sel),
        .gnt    (gnt),
        .valid0 (bus.valid0),
        .valid1 (bus.valid1),
        .last0  (bus.last0),
        .last1  (bus.last1),
        .data0  (bus.data0),
        .data1  (bus.data1),
        .valid  (mux_valid),
        .last   (bus.out_last),
        .data   (bus.out_data)
    );

    // Reset also gates the handshake so nothing transfers in the reset cycle.
    assign bus.out_valid = mux_valid & ~rst;
    assign bus.ready0    = gnt[0] & bus.out_ready & ~rst;
    assign bus.ready1    = gnt[1] & bus.out_ready & ~rst;
    assign bus.gnt       = gnt;
    assign bus.sel       = sel;

    assign req         = {bus.req1, bus.req0};
    assign xfer        = bus.out_valid & bus.out_ready;
    assign cur         = (state == ARB_G1);
    assign at_cap      = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign release_now = xfer & (bus.out_last | at_cap);

    // Who owns the mux next: from IDLE by priority, on release other-first.
    always_comb begin
        nxt_go  = 1'b0;
        nxt_src = SRC0;
        if (state == ARB_IDLE) begin
            nxt_go  = |req;
            nxt_src = (&req) ? prio : req[1];
        end else if (req[~cur]) begin
            nxt_go  = 1'b1;
            nxt_src = ~cur;
        end else if (req[cur]) begin
            nxt_go  = 1'b1;
            nxt_src = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            gnt      <= 2'b00;
            sel      <= SRC0;
            prio     <= SRC0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (nxt_go) begin
                        state <= nxt_src ? ARB_G1 : ARB_G0;
                        gnt   <= gnt_of(nxt_src);
                        sel   <= nxt_src;
                    end
                end
                ARB_G0, ARB_G1: begin
                    if (release_now) begin
                        beat_cnt <= '0;
                        prio     <= ~cur;
                        if (nxt_go) begin
                            state <= nxt_src ? ARB_G1 : ARB_G0;
                            gnt   <= gnt_of(nxt_src);
                            sel   <= nxt_src;
                        end else begin
                            state <= ARB_IDLE;
                            gnt   <= 2'b00;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule
